// File: rtl/write_back_stage.sv
// write_back_stage -- final RV32 pipeline stage.
// Latches one write-back bundle, selects ALU result, extracted load data or
// PC+4, and drives the registered register-file write port. Loads hold the
// stage in WAIT_MEM until the data-memory response arrives. Counts retires.
// Ports:
//   clk, reset_n (sync, active-low)
//   in_valid/in_ready                  upstream handshake
//   in_reg_write_en, in_reg_store_sel  write-back control
//   in_rd, in_alu_result, in_pc, in_funct3  bundle fields
//   mem_rsp_valid, mem_rsp_data        data-memory read response
//   rf_we, rf_waddr, rf_wdata          register-file write port (registered)
//   retire, instret                    retire pulse and counter
package write_back_pkg;
  typedef enum logic [1:0] {
    WRITE_BACK_SEL_ALU = 2'd0,
    WRITE_BACK_SEL_MEM = 2'd1,
    WRITE_BACK_SEL_PC  = 2'd2
  } write_back_select_t;
endpackage

module write_back_stage
  import write_back_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_reg_write_en,
  input  write_back_select_t   in_reg_store_sel,
  input  logic [4:0]           in_rd,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [2:0]           in_funct3,
  input  logic                 mem_rsp_valid,
  input  logic [XLEN-1:0]      mem_rsp_data,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                r_state;
  state_t                w_state_next;

  // Load context captured on accept, consumed when the response arrives.
  logic                  r_ld_we;
  logic [4:0]            r_ld_rd;
  logic [1:0]            r_ld_off;
  logic [2:0]            r_ld_funct3;

  logic                  r_rf_we;
  logic [4:0]            r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;
  logic                  r_retire;
  logic [INSTRET_W-1:0]  r_instret;

  logic                  w_accept;
  logic                  w_done_imm;
  logic                  w_done_mem;
  logic                  w_complete;
  logic                  w_we;
  logic [4:0]            w_waddr;
  logic [XLEN-1:0]       w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_load;

  assign w_accept   = in_valid && in_ready;
  assign w_done_imm = w_accept && (in_reg_store_sel != WRITE_BACK_SEL_MEM);
  assign w_done_mem = (r_state == WAIT_MEM) && mem_rsp_valid;
  assign w_complete = w_done_imm || w_done_mem;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_accept && in_reg_store_sel == WRITE_BACK_SEL_MEM) w_state_next = WAIT_MEM;
      WAIT_MEM: if (mem_rsp_valid) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // Output logic: ready depends on state only
  always_comb begin
    in_ready = (r_state == IDLE);
  end

  // Load alignment and extension
  always_comb begin
    w_byte = mem_rsp_data[7:0];
    case (r_ld_off)
      2'd0: w_byte = mem_rsp_data[7:0];
      2'd1: w_byte = mem_rsp_data[15:8];
      2'd2: w_byte = mem_rsp_data[23:16];
      2'd3: w_byte = mem_rsp_data[31:24];
      default: w_byte = mem_rsp_data[7:0];
    endcase
    w_half = r_ld_off[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (r_ld_funct3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = mem_rsp_data;
    endcase
  end

  // Write-port source: a pending load completes only in WAIT_MEM, when no
  // accept can happen, so the two completion sources never coincide.
  always_comb begin
    w_we    = in_reg_write_en && (in_rd != 5'd0);
    w_waddr = in_rd;
    w_wdata = (in_reg_store_sel == WRITE_BACK_SEL_PC) ? (in_pc + 32'd4) : in_alu_result;
    if (w_done_mem) begin
      w_we    = r_ld_we && (r_ld_rd != 5'd0);
      w_waddr = r_ld_rd;
      w_wdata = w_load;
    end
  end

  // Load context capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ld_we     <= 1'b0;
      r_ld_rd     <= '0;
      r_ld_off    <= '0;
      r_ld_funct3 <= '0;
    end else if (w_accept) begin
      r_ld_we     <= in_reg_write_en;
      r_ld_rd     <= in_rd;
      r_ld_off    <= in_alu_result[1:0];
      r_ld_funct3 <= in_funct3;
    end
  end

  // Register-file write port and retire accounting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_retire   <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_rf_we  <= w_complete && w_we;
      r_retire <= w_complete;
      if (w_complete) begin
        r_rf_waddr <= w_waddr;
        r_rf_wdata <= w_wdata;
        r_instret  <= r_instret + INSTRET_W'(1);
      end
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign retire   = r_retire;
  assign instret  = r_instret;

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Final pipeline stage of the RV32 core: latches one instruction's write-back bundle from the memory stage, selects the write-back value (ALU result, aligned and extended load data, or PC+4), and drives the register-file write port. Loads stall the stage until the data-memory response arrives. The stage also counts retired instructions. Control inputs `in_reg_write_en` and `in_reg_store_sel` come straight from the write-back decode logic.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `INSTRET_W`, 64: retire counter width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream bundle valid.
- `in_ready`  out  1  stage can accept; equals (state == IDLE).
- `in_reg_write_en`  in  1  instruction writes `rd`.
- `in_reg_store_sel`  in  `write_back_select_t`  `WRITE_BACK_SEL_ALU`, `_MEM` or `_PC`.
- `in_rd`  in  5  destination register.
- `in_alu_result`  in  32  ALU result; for loads, the effective address (bits [1:0] used).
- `in_pc`  in  32  instruction PC.
- `in_funct3`  in  3  load width/sign selector.
- `mem_rsp_valid`  in  1  data-memory read response valid.
- `mem_rsp_data`  in  32  aligned 32-bit word containing the load.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_waddr`  out  5  write address (registered).
- `rf_wdata`  out  32  write data (registered).
- `retire`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  `INSTRET_W`  retired-instruction count.

## Operation
- The stage has two states, `IDLE` and `WAIT_MEM`.
- **Accept:** a transfer occurs on an edge where `in_valid && in_ready`. All `in_*` fields are captured on that edge.
- **ALU or PC select:** the instruction completes on the accept edge; the state stays `IDLE`.
  - ALU data is `in_alu_result`.
  - PC data is `in_pc + 4`, modulo 2^32, so 0xFFFFFFFC gives 0x00000000.
- **MEM select:** the accept edge moves the state to `WAIT_MEM`.
  - In `WAIT_MEM`, the first edge with `mem_rsp_valid=1` completes the load and returns the state to `IDLE`.
  - `mem_rsp_valid` is ignored in `IDLE`.
- **Load extract:** `off` is the captured `in_alu_result[1:0]`.
  - `funct3` 000 (LB): byte `off`, sign-extended. 100 (LBU): byte `off`, zero-extended.
  - 001 (LH): halfword `off[1]`, sign-extended; `off[0]` is ignored. 101 (LHU): same halfword, zero-extended.
  - 010 (LW) and all other encodings: the full word.
- **On completion:**
  - `rf_we <= in_reg_write_en && (rd != 0)`; `rf_waddr <= rd`; `rf_wdata <=` the selected value.
  - `retire <= 1`; `instret` increments and wraps at 2^INSTRET_W.
  - An instruction with `in_reg_write_en=0` (store or branch) or `rd=0` still retires but does not write.
- **No completion:** `rf_we` and `retire` are 0 on that edge. `rf_waddr` and `rf_wdata` hold their last values.
- **Reset** (`reset_n=0` at an edge):
  - The state goes to `IDLE`.
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `retire=0`, `instret=0`.
  - A pending load is discarded with no write and no retire.
  - Reset overrides a coincident accept or response.

## Timing
- ALU/PC latency: accepted at edge N → `rf_we`/`retire` high for the cycle after N.
- ALU/PC throughput: back-to-back accepts every cycle give one write per cycle.
- Load latency: accepted at edge N → `in_ready=0` from N+1. With the response at edge M (M ≥ N+1), the write is visible in the cycle after M and `in_ready=1` again after M.
- Minimum load occupancy is 2 cycles, so a load blocks the next instruction for at least one cycle.
- `in_ready` is a pure function of state; it has no combinational path from `in_valid` or `mem_rsp_valid`.
- A response arriving in the same cycle as the load's accept is not sampled. Memory must respond no earlier than the cycle after the accept.
- Holding `in_valid` with an unchanged bundle while `in_ready=0` is legal. The bundle is taken on the first edge where `in_ready=1`.

## Test plan
- **Reset values:** hold `reset_n=0` for 2 cycles → all outputs 0, `in_ready=1`.
- **ALU then PC, back to back:**
  - ALU, rd=5, result 0x1234 → next cycle `rf_we=1`, `waddr=5`, `wdata=0x1234`, `retire=1`.
  - Following cycle, PC (JAL), rd=1, pc=0xFFFFFFFC → `wdata=0x00000000`.
  - `instret=2`.
- **Byte and halfword loads on word 0x80FF7F01:**
  - LB off=3 → 0xFFFFFF80. LBU off=3 → 0x00000080.
  - LH off=2 → 0xFFFF80FF. LHU off=0 → 0x00007F01. LW → 0x80FF7F01.
- **Load stall:**
  - Accept a load, then present an ALU op while delaying the response 3 cycles → `in_ready=0` for 4 cycles.
  - The load writes first; the ALU op writes exactly one cycle later.
- **Non-writing retires:** store (`in_reg_write_en=0`) and ALU with rd=0 → `rf_we=0`, `retire=1` each, `instret` increments by 2.
- **Reset mid-load:** reset in `WAIT_MEM`, then assert `mem_rsp_valid` → no `rf_we`, `instret=0`, state `IDLE`.
- **Counter wrap:** force `instret=2^64-1`, retire one instruction → `instret=0`.
